// File: rtl/wb_ram_arbiter.sv
// Round-robin (or m0 fixed priority with ARB_M0_PRIORITY_EN) Wishbone arbiter onto one single-port RAM.
// Grant at E0, RAM access E0-E1, ack E1-E2; one access per 3 cycles, losers simply wait.
module wb_ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [DATA_W/8-1:0]   m0_sel_i,
  input  logic [31:0]           m0_adr_i,
  input  logic [DATA_W-1:0]     m0_dat_i,
  output logic                  m0_ack_o,
  output logic [DATA_W-1:0]     m0_dat_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [DATA_W/8-1:0]   m1_sel_i,
  input  logic [31:0]           m1_adr_i,
  input  logic [DATA_W-1:0]     m1_dat_i,
  output logic                  m1_ack_o,
  output logic [DATA_W-1:0]     m1_dat_o,
  output logic                  ram_en_o,
  output logic [DATA_W/8-1:0]   ram_we_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic [DATA_W-1:0]     ram_di_o,
  input  logic [DATA_W-1:0]     ram_do_i,
  output logic                  busy_o
);
  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              r_state;
  logic                r_gnt;
  logic                r_rd;
  logic                r_ack0;
  logic                r_ack1;
  logic                r_en;
  logic [SEL_W-1:0]    r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_di;
  logic                r_busy;

  logic                w_req0;
  logic                w_req1;
  logic                w_gnt;
  logic                w_we;
  logic [SEL_W-1:0]    w_sel;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_di;
  logic                w_unused;

  assign w_req0 = m0_cyc_i & m0_stb_i;
  assign w_req1 = m1_cyc_i & m1_stb_i;

`ifdef ARB_M0_PRIORITY_EN
  assign w_gnt = ~w_req0;
`else
  logic r_last;
  // r_last resets to 1 so master 0 wins the first tie
  assign w_gnt = (w_req0 & w_req1) ? ~r_last : w_req1;
`endif

  assign w_we   = w_gnt ? m1_we_i  : m0_we_i;
  assign w_sel  = w_gnt ? m1_sel_i : m0_sel_i;
  assign w_addr = w_gnt ? m1_adr_i[ADDR_W+1:2] : m0_adr_i[ADDR_W+1:2];
  assign w_di   = w_gnt ? m1_dat_i : m0_dat_i;

  // Upper and byte-offset address bits are don't-care: the RAM aliases.
  assign w_unused = &{1'b0, m0_adr_i[31:ADDR_W+2], m0_adr_i[1:0],
                      m1_adr_i[31:ADDR_W+2], m1_adr_i[1:0]};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_rd    <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_en    <= 1'b0;
      r_we    <= '0;
      r_addr  <= '0;
      r_di    <= '0;
      r_busy  <= 1'b0;
`ifndef ARB_M0_PRIORITY_EN
      r_last  <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_state <= S_ACCESS;
            r_busy  <= 1'b1;
            r_gnt   <= w_gnt;
`ifndef ARB_M0_PRIORITY_EN
            r_last  <= w_gnt;
`endif
            r_en    <= 1'b1;
            r_we    <= w_we ? w_sel : '0;
            r_addr  <= w_addr;
            r_di    <= w_di;
            r_rd    <= ~w_we;
          end
        end
        S_ACCESS: begin
          // The RAM commits at this edge regardless; only the ack honours an abort.
          r_state <= S_RESP;
          r_en    <= 1'b0;
          r_we    <= '0;
          r_ack0  <= ~r_gnt & m0_cyc_i;
          r_ack1  <= r_gnt & m1_cyc_i;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_en    <= 1'b0;
          r_we    <= '0;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_en_o   = r_en;
  assign ram_we_o   = r_we;
  assign ram_addr_o = r_addr;
  assign ram_di_o   = r_di;
  assign busy_o     = r_busy;
  assign m0_ack_o   = r_ack0;
  assign m1_ack_o   = r_ack1;

  // RAM read data only exists during RESP, so it is steered through by the registered ack.
  assign m0_dat_o = (r_ack0 & r_rd) ? ram_do_i : '0;
  assign m1_dat_o = (r_ack1 & r_rd) ? ram_do_i : '0;

endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
Two-master Wishbone (classic) arbiter that shares one single-port DFFRAM macro inside the Ibtida user project.
- Master 0: the management SoC port (wbs_* from the user wrapper).
- Master 1: the Ibtida core data bus.
- Arbitrates round-robin, sequences each RAM access and returns ack/read data to the winning master.

Parameters:
ADDR_W, 10, RAM word-address width (RAM depth = 2**ADDR_W 32-bit words)
DATA_W, 32, data width; fixed at 32, byte lanes = DATA_W/8

Ports:
wb_clk_i  in  1  system clock, rising edge
wb_rst_ni  in  1  asynchronous active-low reset
m0_cyc_i  in  1  master 0 cycle
m0_stb_i  in  1  master 0 strobe
m0_we_i  in  1  master 0 write enable
m0_sel_i  in  4  master 0 byte selects
m0_adr_i  in  32  master 0 byte address
m0_dat_i  in  32  master 0 write data
m0_ack_o  out  1  master 0 acknowledge
m0_dat_o  out  32  master 0 read data
m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i, m1_ack_o, m1_dat_o: same as master 0, for master 1
ram_en_o  out  1  RAM enable
ram_we_o  out  4  RAM per-byte write enable
ram_addr_o  out  ADDR_W  RAM word address
ram_di_o  out  32  RAM write data
ram_do_i  in  32  RAM read data, valid the cycle after ram_en_o
busy_o  out  1  arbiter not in IDLE

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_ni is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - All outputs 0: ram_en_o, ram_we_o, ram_addr_o, ram_di_o, m0/m1_ack_o, m0/m1_dat_o, busy_o.
  - Internal last-served pointer = 1, so master 0 wins the first tie.
- Request: req_n = mN_cyc_i & mN_stb_i.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that master.
  - Both request: grant the master that is not last-served.
  - On the grant edge, register the grant and update last-served. Load:
    - ram_addr_o = adr[ADDR_W+1:2]
    - ram_di_o = dat_i
    - ram_we_o = we ? sel : 4'b0
    - ram_en_o = 1
  - Go to ACCESS.
- ACCESS (1 cycle):
  - The RAM captures the access at the ending edge.
  - At that edge, ram_en_o and ram_we_o return to 0.
  - Go to RESP.
- RESP (1 cycle):
  - Granted master's ack_o = 1.
  - Its dat_o = ram_do_i for reads, 0 for writes.
  - At the end of RESP, ack_o and dat_o return to 0 and the FSM goes to IDLE.
- Latency: request sampled at edge E0 -> ack high between E1 and E2. Issue rate is one access per 3 cycles. The FSM never re-samples a master in the same cycle it is acked.
- The non-granted master's ack_o and dat_o stay 0 at all times.
- Address bits above ADDR_W+1 and bits [1:0] are ignored, so the RAM aliases across the address space. Every access is acked; there is no error response.
- Abort: if the granted master drops cyc_i during ACCESS, the RAM access still completes (writes land). The ack in RESP is suppressed.
- Inputs change while granted: ignored after the IDLE sample, because the registered copy is used.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0. A write is committed only if its ACCESS edge occurred before reset assertion.
- busy_o = (state != IDLE).

Optional Feature:
Macro ARB_M0_PRIORITY_EN.
- Defined: fixed priority. Master 0 always wins when both request; the last-served pointer is unused.
- Undefined: round-robin as specified above.

Test Plan:
1. Single write then read by m0: write adr 0x0000_0010, dat 0xCAFEBABE, sel 4'hF -> ram_addr_o = 4, ram_we_o = 4'hF. Then read the same address -> m0_ack_o 2 cycles after request, m0_dat_o = 0xCAFEBABE.
2. Byte write by m1: sel 4'b0010 to adr 0x8 -> ram_we_o = 4'b0010 for exactly one cycle. m0_ack_o stays 0 throughout.
3. Simultaneous continuous requests from both masters after reset -> grants alternate m0, m1, m0, m1. Each ack is exactly one cycle; accesses are 3 cycles apart.
4. Abort: m1 drops cyc in ACCESS on a write -> RAM write still issued, m1_ack_o never asserts, FSM back in IDLE after 2 cycles.
5. Reset asserted during RESP -> all outputs 0 immediately (asynchronously), busy_o = 0. After release, a tie grants m0 first.
6. With ARB_M0_PRIORITY_EN defined, both masters requesting continuously -> m0 granted every time, m1 starved.
